// File: rtl/sn74193.sv
// SN74193 4-bit presettable up/down counter, clocked on CLK_DRV with edge-detected UP/DOWN.
// Define SN74193_INPUT_SYNC_EN to pass all inputs through two-flop synchronizers.
module sn74193 (
    input  logic CLK_DRV,
    input  logic RESET,
    input  logic UP,
    input  logic DOWN,
    input  logic CLR,
    input  logic LOAD_N,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    output logic QA,
    output logic QB,
    output logic QC,
    output logic QD,
    output logic CO_N,
    output logic BO_N
);

    logic       w_up;
    logic       w_dn;
    logic       w_clr;
    logic       w_load_n;
    logic [3:0] w_data;

`ifdef SN74193_INPUT_SYNC_EN
    // Bit order {UP, DOWN, CLR, LOAD_N, D, C, B, A}; idle values on reset
    localparam logic [7:0] SYNC_RST = 8'b1101_0000;

    logic [7:0] r_s1;
    logic [7:0] r_s2;

    always_ff @(posedge CLK_DRV) begin
        if (RESET) begin
            r_s1 <= SYNC_RST;
            r_s2 <= SYNC_RST;
        end else begin
            r_s1 <= {UP, DOWN, CLR, LOAD_N, D, C, B, A};
            r_s2 <= r_s1;
        end
    end

    assign w_up     = r_s2[7];
    assign w_dn     = r_s2[6];
    assign w_clr    = r_s2[5];
    assign w_load_n = r_s2[4];
    assign w_data   = r_s2[3:0];
`else
    assign w_up     = UP;
    assign w_dn     = DOWN;
    assign w_clr    = CLR;
    assign w_load_n = LOAD_N;
    assign w_data   = {D, C, B, A};
`endif

    logic [3:0] r_cnt;
    logic       r_up_d;
    logic       r_dn_d;
    logic       w_up_rise;
    logic       w_dn_rise;
    logic [3:0] w_cnt_nxt;

    assign w_up_rise = w_up & ~r_up_d;
    assign w_dn_rise = w_dn & ~r_dn_d;

    // Clear beats load beats counting; simultaneous edges cancel
    always_comb begin
        w_cnt_nxt = r_cnt;
        priority case (1'b1)
            w_clr:
                w_cnt_nxt = 4'd0;
            !w_load_n:
                w_cnt_nxt = w_data;
            (w_up_rise & w_dn & ~w_dn_rise):
                w_cnt_nxt = r_cnt + 4'd1;
            (w_dn_rise & w_up & ~w_up_rise):
                w_cnt_nxt = r_cnt - 4'd1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK_DRV) begin
        if (RESET) begin
            r_cnt  <= 4'd0;
            r_up_d <= 1'b1;
            r_dn_d <= 1'b1;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_up_d <= w_up;
            r_dn_d <= w_dn;
        end
    end

    assign {QD, QC, QB, QA} = r_cnt;
    assign CO_N = ~((r_cnt == 4'hF) & ~w_up);
    assign BO_N = ~((r_cnt == 4'h0) & ~w_dn);

endmodule

// File: tb/tb_sn74193.sv
// Directed bench for sn74193: a driven lower counter cascaded into an upper one
// through CO_N.
module tb_sn74193;

    logic       clk = 1'b0;
    logic       rst;
    logic       up;
    logic       dn;
    logic       clr;
    logic       load_n;
    logic [3:0] din;

    logic       lo_qa, lo_qb, lo_qc, lo_qd, lo_co, lo_bo;
    logic       hi_qa, hi_qb, hi_qc, hi_qd, hi_co, hi_bo;
    logic [3:0] lo_q;
    logic [3:0] hi_q;

    int n_chk = 0;
    int n_err = 0;
    int exp_q;

    always #5 clk = ~clk;

    assign lo_q = {lo_qd, lo_qc, lo_qb, lo_qa};
    assign hi_q = {hi_qd, hi_qc, hi_qb, hi_qa};

    sn74193 u_lo (
        .CLK_DRV (clk),
        .RESET   (rst),
        .UP      (up),
        .DOWN    (dn),
        .CLR     (clr),
        .LOAD_N  (load_n),
        .A       (din[0]),
        .B       (din[1]),
        .C       (din[2]),
        .D       (din[3]),
        .QA      (lo_qa),
        .QB      (lo_qb),
        .QC      (lo_qc),
        .QD      (lo_qd),
        .CO_N    (lo_co),
        .BO_N    (lo_bo)
    );

    sn74193 u_hi (
        .CLK_DRV (clk),
        .RESET   (rst),
        .UP      (lo_co),
        .DOWN    (1'b1),
        .CLR     (1'b0),
        .LOAD_N  (1'b1),
        .A       (1'b0),
        .B       (1'b0),
        .C       (1'b0),
        .D       (1'b0),
        .QA      (hi_qa),
        .QB      (hi_qb),
        .QC      (hi_qc),
        .QD      (hi_qd),
        .CO_N    (hi_co),
        .BO_N    (hi_bo)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst    = 1'b1;
        up     = 1'b0;
        dn     = 1'b0;
        clr    = 1'b0;
        load_n = 1'b1;
        din    = 4'h0;
        tick(2);

        // Reset state with DOWN low: borrow asserted at zero
        chk("rst_q", lo_q, 4'h0);
        chk("rst_co", {3'b0, lo_co}, 4'h1);
        chk("rst_bo_dn0", {3'b0, lo_bo}, 4'h0);
        dn = 1'b1;
        tick(1);
        chk("rst_bo_dn1", {3'b0, lo_bo}, 4'h1);

        // Up count, 17 rising edges, slow UP
        rst = 1'b0;
        tick(2);
        exp_q = 0;
        for (int i = 0; i < 17; i++) begin
            up = 1'b1;
            tick(50);
            exp_q = (exp_q + 1) % 16;
            chk("up_q", lo_q, 4'(exp_q));
            chk("up_co_hi", {3'b0, lo_co}, 4'h1);
            up = 1'b0;
            tick(50);
            chk("up_co_lo", {3'b0, lo_co},
                (exp_q == 15) ? 4'h0 : 4'h1);
        end

        // Down count from reset with borrow
        rst = 1'b1;
        up  = 1'b1;
        dn  = 1'b0;
        tick(2);
        chk("dn_rst_bo", {3'b0, lo_bo}, 4'h0);
        rst = 1'b0;
        tick(2);
        chk("dn_pre_bo", {3'b0, lo_bo}, 4'h0);
        chk("dn_pre_q", lo_q, 4'h0);
        dn = 1'b1;
        tick(4);
        chk("dn_q15", lo_q, 4'hF);
        chk("dn_bo_rel", {3'b0, lo_bo}, 4'h1);
        dn = 1'b0;
        tick(4);
        dn = 1'b1;
        tick(4);
        chk("dn_q14", lo_q, 4'hE);

        // Level-sensitive load, edge lost during load
        load_n = 1'b0;
        din    = 4'b1010;
        tick(2);
        chk("ld_1010", lo_q, 4'hA);
        din = 4'b0110;
        tick(2);
        chk("ld_0110", lo_q, 4'h6);
        up = 1'b0;
        tick(2);
        up = 1'b1;
        tick(2);
        chk("ld_up_ign", lo_q, 4'h6);
        load_n = 1'b1;
        up     = 1'b0;
        tick(2);
        up = 1'b1;
        tick(2);
        chk("ld_then_up", lo_q, 4'h7);

        // Clear wins over load and an UP edge
        up = 1'b0;
        tick(2);
        clr    = 1'b1;
        load_n = 1'b0;
        din    = 4'hF;
        up     = 1'b1;
        tick(1);
        chk("clr_prio", lo_q, 4'h0);
        clr    = 1'b0;
        load_n = 1'b1;
        tick(2);
        chk("clr_hold", lo_q, 4'h0);
        up = 1'b0;
        tick(2);
        up = 1'b1;
        tick(2);
        chk("clr_up", lo_q, 4'h1);

        // Simultaneous edges, then edges with the other input low
        up = 1'b0;
        dn = 1'b0;
        tick(2);
        up = 1'b1;
        dn = 1'b1;
        tick(2);
        chk("simul", lo_q, 4'h1);
        dn = 1'b0;
        tick(2);
        up = 1'b0;
        tick(2);
        up = 1'b1;
        tick(2);
        chk("up_dn0", lo_q, 4'h1);
        up = 1'b0;
        tick(2);
        dn = 1'b1;
        tick(2);
        chk("dn_up0", lo_q, 4'h1);

        // Cascade: 20 edges gives upper 1, lower 4
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        chk("cas_rst_hi", hi_q, 4'h0);
        for (int i = 0; i < 20; i++) begin
            up = 1'b1;
            tick(3);
            up = 1'b0;
            tick(3);
        end
        chk("cas_lo", lo_q, 4'h4);
        chk("cas_hi", hi_q, 4'h1);

        // Mid-count reset at 9 with UP held high
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        for (int i = 0; i < 9; i++) begin
            up = 1'b1;
            tick(3);
            if (i != 8) begin
                up = 1'b0;
                tick(3);
            end
        end
        chk("mid_q9", lo_q, 4'h9);
        rst = 1'b1;
        tick(1);
        chk("mid_rst", lo_q, 4'h0);
        rst = 1'b0;
        tick(2);
        chk("mid_no_edge", lo_q, 4'h0);
        up = 1'b0;
        tick(2);
        up = 1'b1;
        tick(2);
        chk("mid_first", lo_q, 4'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
